dds_voice_scheduler: RTL and testbench

Time-multiplexed phase-accumulator scheduler for the polyphonic FM synth. It shares one 32-bit phase adder among `NUM_VOICES` voices, each with its own stored phase and frequency control word. On every sample tick it steps all voices in a fixed round-robin sweep. It emits one truncated LUT phase per voice to the sine-lookup stage. It also owns the configuration port through which the control plane writes per-voice increments, enables and phase clears.

---
 rtl/dds_pkg.sv | 16 +
 rtl/dds_voice_scheduler_if.sv | 36 +++
 rtl/dds_phase_step.sv | 27 ++
 rtl/dds_voice_scheduler.sv | 163 ++++++++++++++++
 tb/tb_dds_voice_scheduler.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared types and default sizing for the DDS voice scheduler.
// Contents:
//   NUM_VOICES_DEF, PHASE_W_DEF, OUT_W_DEF - default parameter values
//   sched_state_t                          - scheduler FSM state
//   phase_t                                - full-width phase word at default width
package dds_pkg;

  localparam int unsigned NUM_VOICES_DEF = 8;
  localparam int unsigned PHASE_W_DEF    = 32;
  localparam int unsigned OUT_W_DEF      = 12;

  typedef enum logic {IDLE, RUN} sched_state_t;

  typedef logic [PHASE_W_DEF-1:0] phase_t;

endpackage

// File: rtl/dds_voice_scheduler_if.sv
// Configuration write port and per-voice phase output stream of the DDS voice scheduler.
// master: control plane / sine-lookup side (drives cfg_*, receives phase stream).
// slave : the scheduler (accepts cfg_*, drives cfg_ready and the phase stream).
//   cfg_valid/cfg_ready  - write handshake; cfg_voice, cfg_inc, cfg_en, cfg_phase_clr payload
//   phase_valid          - phase_voice/phase_out valid this cycle
//   frame_done           - pulses with the last voice's output
interface dds_voice_scheduler_if #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned OUT_W      = 12,
  localparam int unsigned VW        = $clog2(NUM_VOICES)
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [VW-1:0]      cfg_voice;
  logic [PHASE_W-1:0] cfg_inc;
  logic               cfg_en;
  logic               cfg_phase_clr;

  logic               phase_valid;
  logic [VW-1:0]      phase_voice;
  logic [OUT_W-1:0]   phase_out;
  logic               frame_done;

  modport master (
    output cfg_valid, cfg_voice, cfg_inc, cfg_en, cfg_phase_clr,
    input  cfg_ready, phase_valid, phase_voice, phase_out, frame_done
  );

  modport slave (
    input  cfg_valid, cfg_voice, cfg_inc, cfg_en, cfg_phase_clr,
    output cfg_ready, phase_valid, phase_voice, phase_out, frame_done
  );

endinterface

// File: rtl/dds_phase_step.sv
// Combinational phase step for one voice slot.
//   phase_i, inc_i - stored phase and increment of the voice being processed
//   en_i           - voice enable; a disabled voice is forced to phase 0
//   phase_o        - next stored phase (phase_i + inc_i mod 2^PHASE_W, or 0)
//   trunc_o        - top OUT_W bits of phase_o for the sine lookup
module dds_phase_step #(
  parameter int unsigned PHASE_W = dds_pkg::PHASE_W_DEF,
  parameter int unsigned OUT_W   = dds_pkg::OUT_W_DEF
) (
  input  logic [PHASE_W-1:0] phase_i,
  input  logic [PHASE_W-1:0] inc_i,
  input  logic               en_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic [OUT_W-1:0]   trunc_o
);
  import dds_pkg::*;

  always_comb begin
    phase_o = '0;
    if (en_i) begin
      phase_o = phase_i + inc_i;
    end
  end

  assign trunc_o = phase_o[PHASE_W-1 -: OUT_W];

endmodule

// File: rtl/dds_voice_scheduler.sv
// Time-multiplexed phase-accumulator scheduler: one shared adder steps NUM_VOICES voices in a
// round-robin sweep per sample_tick and streams one truncated phase per voice.
// Ports:
//   clk, reset_n  - clock; synchronous active-low reset
//   sample_tick   - frame start strobe (accepted only when idle)
//   busy          - sweep in progress
//   overrun       - sticky flag: tick arrived while busy (only with DDS_SCHED_OVERRUN_EN)
//   overrun_clr   - clears overrun (set wins on the same cycle)
//   bus           - config write port and phase output stream (slave side)
// Build option: define DDS_SCHED_OVERRUN_EN to enable the overrun flag; otherwise it reads 0.
module dds_voice_scheduler #(
  parameter int unsigned NUM_VOICES = dds_pkg::NUM_VOICES_DEF,
  parameter int unsigned PHASE_W    = dds_pkg::PHASE_W_DEF,
  parameter int unsigned OUT_W      = dds_pkg::OUT_W_DEF,
  localparam int unsigned VW        = $clog2(NUM_VOICES)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sample_tick,
  input  logic                        overrun_clr,
  output logic                        busy,
  output logic                        overrun,
  dds_voice_scheduler_if.slave        bus
);
  import dds_pkg::*;

  sched_state_t state_q, state_d;
  logic [VW-1:0] slot_q, slot_d;

  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d [NUM_VOICES];
  logic [PHASE_W-1:0] inc_q   [NUM_VOICES];
  logic [PHASE_W-1:0] inc_d   [NUM_VOICES];
  logic [NUM_VOICES-1:0] en_q, en_d;

  logic             phase_valid_q, phase_valid_d;
  logic [VW-1:0]    phase_voice_q, phase_voice_d;
  logic [OUT_W-1:0] phase_out_q, phase_out_d;
  logic             frame_done_q, frame_done_d;

  logic [PHASE_W-1:0] step_phase;
  logic [OUT_W-1:0]   step_trunc;
  logic               last_slot;
  logic               cfg_hit;

  assign last_slot = (slot_q == VW'(NUM_VOICES - 1));
  // Out-of-range voices still complete the handshake but touch nothing.
  assign cfg_hit   = bus.cfg_valid && (state_q == IDLE) && (32'(bus.cfg_voice) < NUM_VOICES);

  dds_phase_step #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) u_step (
    .phase_i (phase_q[slot_q]),
    .inc_i   (inc_q[slot_q]),
    .en_i    (en_q[slot_q]),
    .phase_o (step_phase),
    .trunc_o (step_trunc)
  );

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    phase_d       = phase_q;
    inc_d         = inc_q;
    en_d          = en_q;
    phase_valid_d = 1'b0;
    phase_voice_d = '0;
    phase_out_d   = '0;
    frame_done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Config lands in the same cycle as a tick, so the new frame sees it.
        if (cfg_hit) begin
          inc_d[bus.cfg_voice] = bus.cfg_inc;
          en_d[bus.cfg_voice]  = bus.cfg_en;
          if (bus.cfg_phase_clr) begin
            phase_d[bus.cfg_voice] = '0;
          end
        end
        if (sample_tick) begin
          state_d = RUN;
          slot_d  = '0;
        end
      end
      RUN: begin
        phase_d[slot_q] = step_phase;
        phase_valid_d   = 1'b1;
        phase_voice_d   = slot_q;
        phase_out_d     = step_trunc;
        frame_done_d    = last_slot;
        if (last_slot) begin
          state_d = IDLE;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= '0;
        inc_q[v]   <= '0;
      end
      en_q          <= '0;
      phase_valid_q <= 1'b0;
      phase_voice_q <= '0;
      phase_out_q   <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      phase_q       <= phase_d;
      inc_q         <= inc_d;
      en_q          <= en_d;
      phase_valid_q <= phase_valid_d;
      phase_voice_q <= phase_voice_d;
      phase_out_q   <= phase_out_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign busy            = (state_q == RUN);
  assign bus.cfg_ready   = (state_q == IDLE);
  assign bus.phase_valid = phase_valid_q;
  assign bus.phase_voice = phase_voice_q;
  assign bus.phase_out   = phase_out_q;
  assign bus.frame_done  = frame_done_q;

`ifdef DDS_SCHED_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (sample_tick && (state_q == RUN)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  logic unused_overrun_clr;
  assign unused_overrun_clr = overrun_clr;
  assign overrun            = 1'b0;
`endif

endmodule

// File: tb/tb_dds_voice_scheduler.sv
module tb_dds_voice_scheduler;

  localparam int N = 8;

`ifdef DDS_SCHED_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sample_tick = 1'b0;
  logic overrun_clr = 1'b0;
  logic busy;
  logic overrun;

  dds_voice_scheduler_if #(.NUM_VOICES(N), .PHASE_W(32), .OUT_W(12)) bus ();

  dds_voice_scheduler #(
    .NUM_VOICES (N),
    .PHASE_W    (32),
    .OUT_W      (12)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .overrun_clr (overrun_clr),
    .busy        (busy),
    .overrun     (overrun),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Reference model: per-voice accumulator state as the control plane sees it.
  logic [31:0] m_phase [N];
  logic [31:0] m_inc   [N];
  bit          m_en    [N];
  logic [11:0] got_out [N];

  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_phase[v] = '0;
      m_inc[v]   = '0;
      m_en[v]    = 1'b0;
    end
  endtask

  // Drive a write in the current (idle) cycle; caller decides when the cycle ends.
  task automatic cfg_drive(input int v, input logic [31:0] inc, input bit en, input bit clr);
    bus.cfg_valid     = 1'b1;
    bus.cfg_voice     = 3'(v);
    bus.cfg_inc       = inc;
    bus.cfg_en        = en;
    bus.cfg_phase_clr = clr;
    vectors++;
    if (bus.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_ready_idle got %b exp 1", bus.cfg_ready);
    end
    if (v < N) begin
      m_inc[v] = inc;
      m_en[v]  = en;
      if (clr) m_phase[v] = '0;
    end
  endtask

  task automatic cfg_write(input int v, input logic [31:0] inc, input bit en, input bit clr);
    cfg_drive(v, inc, en, clr);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  // Entered at the negedge of cycle T; drives the tick and checks the whole sweep.
  // inject: 0 none, 1 tick at T+3, 2 tick plus overrun_clr at T+3. chain: tick again at T+N+1.
  task automatic frame(input bit chain, input int inject);
    logic [11:0] exp_out [N];
    bit exp_busy;
    for (int v = 0; v < N; v++) begin
      if (m_en[v]) m_phase[v] = m_phase[v] + m_inc[v];
      else         m_phase[v] = '0;
      exp_out[v] = m_phase[v][31:20];
    end
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick   = 1'b0;
    bus.cfg_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || bus.cfg_ready !== 1'b0 || bus.phase_valid !== 1'b0 ||
        bus.frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_start busy/ready/valid/done got %b%b%b%b exp 1000",
               busy, bus.cfg_ready, bus.phase_valid, bus.frame_done);
    end
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      exp_busy = (k <= N - 2);
      got_out[k] = bus.phase_out;
      vectors++;
      if (bus.phase_valid !== 1'b1 || bus.phase_voice !== 3'(k) || bus.phase_out !== exp_out[k]) begin
        miscompares++;
        $display("FAIL slot%0d valid/voice/out got %b/%0d/%h exp 1/%0d/%h",
                 k, bus.phase_valid, bus.phase_voice, bus.phase_out, k, exp_out[k]);
      end
      vectors++;
      if (bus.frame_done !== (k == N - 1) || busy !== exp_busy || bus.cfg_ready !== !exp_busy) begin
        miscompares++;
        $display("FAIL slot%0d done/busy/ready got %b%b%b exp %b%b%b", k, bus.frame_done, busy,
                 bus.cfg_ready, (k == N - 1), exp_busy, !exp_busy);
      end
      sample_tick = ((inject != 0) && k == 1) || (chain && k == N - 1);
      overrun_clr = (inject == 2) && k == 1;
    end
    overrun_clr = 1'b0;
  endtask

  task automatic idle_check(input int cycles, input string name);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.phase_valid !== 1'b0 || busy !== 1'b0 || bus.frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s idle valid/busy/done got %b%b%b exp 000", name, bus.phase_valid, busy,
                 bus.frame_done);
      end
    end
  endtask

  task automatic check_quiet(input string name);
    vectors++;
    if (bus.phase_valid !== 1'b0 || bus.phase_voice !== 3'd0 || bus.phase_out !== 12'h000 ||
        bus.frame_done !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s valid/voice/out/done/busy/ovr/ready got %b/%0d/%h/%b/%b/%b/%b exp 0/0/000/0/0/0/1",
               name, bus.phase_valid, bus.phase_voice, bus.phase_out, bus.frame_done, busy,
               overrun, bus.cfg_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_quiet("post_reset");
  endtask

  task automatic test_wrap();
    cfg_write(0, 32'h0010_0000, 1'b1, 1'b0);
    cfg_write(1, 32'h8000_0000, 1'b1, 1'b0);
    frame(1'b0, 0);
    vectors++;
    if (got_out[0] !== 12'h001 || got_out[1] !== 12'h800) begin
      miscompares++;
      $display("FAIL wrap_frame1 got %h %h exp 001 800", got_out[0], got_out[1]);
    end
    idle_check(1, "wrap");
    frame(1'b0, 0);
    vectors++;
    if (got_out[0] !== 12'h002 || got_out[1] !== 12'h000) begin
      miscompares++;
      $display("FAIL wrap_frame2 got %h %h exp 002 000", got_out[0], got_out[1]);
    end
    idle_check(1, "wrap2");
  endtask

  // Back-to-back frames at the minimum tick period of N+1 cycles.
  task automatic test_timing();
    frame(1'b1, 0);
    frame(1'b0, 0);
    idle_check(2, "timing");
  endtask

  task automatic test_overrun();
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_pre got %b exp 0", overrun);
    end
    frame(1'b0, 1);
    vectors++;
    if (overrun !== OVR) begin
      miscompares++;
      $display("FAIL overrun_set got %b exp %b", overrun, OVR);
    end
    idle_check(3, "overrun_no_extra_frame");
    vectors++;
    if (overrun !== OVR) begin
      miscompares++;
      $display("FAIL overrun_sticky got %b exp %b", overrun, OVR);
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clr got %b exp 0", overrun);
    end
    // Clear and set in the same cycle: set wins.
    frame(1'b0, 2);
    vectors++;
    if (overrun !== OVR) begin
      miscompares++;
      $display("FAIL overrun_set_wins got %b exp %b", overrun, OVR);
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    idle_check(1, "overrun_tail");
  endtask

  task automatic test_clear_disable();
    model_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cfg_write(0, 32'h0010_0000, 1'b1, 1'b0);
    repeat (3) frame(1'b0, 0);
    vectors++;
    if (got_out[0] !== 12'h003) begin
      miscompares++;
      $display("FAIL clr_pre got %h exp 003", got_out[0]);
    end
    cfg_write(0, 32'h0010_0000, 1'b1, 1'b1);
    frame(1'b0, 0);
    vectors++;
    if (got_out[0] !== 12'h001) begin
      miscompares++;
      $display("FAIL clr_post got %h exp 001", got_out[0]);
    end
    cfg_write(0, 32'h0010_0000, 1'b0, 1'b0);
    frame(1'b0, 0);
    vectors++;
    if (got_out[0] !== 12'h000) begin
      miscompares++;
      $display("FAIL disable got %h exp 000", got_out[0]);
    end
    idle_check(1, "clear_disable");
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(0, 3)) begin
        cfg_write(int'($urandom_range(0, N - 1)), $urandom(), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0));
      end
      idle_check(int'($urandom_range(0, 2)), "random_gap");
      // Sometimes issue a write in the same cycle as the tick.
      if ($urandom_range(0, 1) == 1) begin
        cfg_drive(int'($urandom_range(0, N - 1)), $urandom(), 1'b1, ($urandom_range(0, 1) == 1));
      end
      frame(1'b0, 0);
    end
    idle_check(1, "random_tail");
  endtask

  task automatic test_reset_mid_frame();
    cfg_write(3, $urandom() | 32'h0100_0000, 1'b1, 1'b0);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("reset_mid_frame");
    end
    reset_n = 1'b1;
    model_reset();
    frame(1'b0, 0);
    idle_check(1, "after_mid_reset");
  endtask

  initial begin
    bus.cfg_valid     = 1'b0;
    bus.cfg_voice     = '0;
    bus.cfg_inc       = '0;
    bus.cfg_en        = 1'b0;
    bus.cfg_phase_clr = 1'b0;
    model_reset();
    test_reset();
    test_wrap();
    test_timing();
    test_overrun();
    test_clear_disable();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
